// File: rtl/tdc_hw_stats.sv
// Window statistics over the TDC Hamming-weight stream: sum, mean, min and max of
// 2^LOG2_SAMPLES valid codes, presented on a valid/ready result port.
module tdc_hw_stats #(
    parameter  int N            = 64,
    parameter  int LOG2_SAMPLES = 4,
    parameter  int DROP_W       = 8,
    localparam int W            = $clog2(N) + 1,
    localparam int SW           = W + LOG2_SAMPLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              cont,
    input  logic [W-1:0]      hw,
    input  logic              hw_val,
    output logic [SW-1:0]     res_sum,
    output logic [W-1:0]      res_mean,
    output logic [W-1:0]      res_min,
    output logic [W-1:0]      res_max,
    output logic              res_val,
    input  logic              res_rdy,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state;
    logic [SW-1:0]           acc;
    logic [W-1:0]            cur_min;
    logic [W-1:0]            cur_max;
    logic [LOG2_SAMPLES-1:0] cnt;

    logic          take;
    logic          last;
    logic [SW-1:0] sum_nxt;
    logic [W-1:0]  min_nxt;
    logic [W-1:0]  max_nxt;

    // Running values including the sample offered this cycle; the final sample
    // of a window loads straight from these into the result registers.
    assign take    = en && hw_val;
    assign last    = (cnt == '1);
    assign sum_nxt = acc + SW'(hw);
    assign min_nxt = (hw < cur_min) ? hw : cur_min;
    assign max_nxt = (hw > cur_max) ? hw : cur_max;

    // NOTE: every register below is written with <= so all of them update from
    // the same pre-edge values; blocking assignments here would chain updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cur_min  <= '1;
            cur_max  <= '0;
            cnt      <= '0;
            res_sum  <= '0;
            res_mean <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_val  <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (start || cont)) begin
                        state   <= ACCUM;
                        busy    <= 1'b1;
                        acc     <= '0;
                        cnt     <= '0;
                        cur_min <= '1;
                        cur_max <= '0;
                        if (start) drop_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc     <= sum_nxt;
                        cur_min <= min_nxt;
                        cur_max <= max_nxt;
                        cnt     <= cnt + 1'b1;
                        if (last) begin
                            state    <= HOLD;
                            busy     <= 1'b0;
                            res_val  <= 1'b1;
                            res_sum  <= sum_nxt;
                            res_mean <= sum_nxt[SW-1:LOG2_SAMPLES];
                            res_min  <= min_nxt;
                            res_max  <= max_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (take && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
                    // The handshake is honoured even while en is low so that the
                    // consumer is never stalled by a frozen engine.
                    if (res_rdy) begin
                        res_val <= 1'b0;
                        if (cont) begin
                            state   <= ACCUM;
                            busy    <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            cur_min <= '1;
                            cur_max <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hw_stats.sv
// Directed bench for tdc_hw_stats: a table of 16-sample windows with expected
// statistics, followed by hand-written drop, enable, continuous and reset sequences.
module tb_tdc_hw_stats;

    localparam int N  = 64;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int W  = $clog2(N) + 1;
    localparam int SW = W + L;
    localparam int NS = 1 << L;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic [W-1:0]  hw = '0;
    logic          hw_val = 1'b0;
    logic          res_rdy = 1'b0;
    logic [SW-1:0] res_sum;
    logic [W-1:0]  res_mean;
    logic [W-1:0]  res_min;
    logic [W-1:0]  res_max;
    logic          res_val;
    logic          busy;
    logic [D-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    tdc_hw_stats #(.N(N), .LOG2_SAMPLES(L), .DROP_W(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .cont     (cont),
        .hw       (hw),
        .hw_val   (hw_val),
        .res_sum  (res_sum),
        .res_mean (res_mean),
        .res_min  (res_min),
        .res_max  (res_max),
        .res_val  (res_val),
        .res_rdy  (res_rdy),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0][W-1:0] s;
        int                   sum;
        int                   mean;
        int                   mn;
        int                   mx;
    } win_vec_t;

    win_vec_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] v);
        hw     = v;
        hw_val = 1'b1;
        tick();
        hw_val = 1'b0;
    endtask

    task automatic handshake();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    task automatic check_result(input string tag, input int s, input int m, input int mn, input int mx);
        check({tag, " res_val"}, res_val, 1);
        check({tag, " res_sum"}, res_sum, s);
        check({tag, " res_mean"}, res_mean, m);
        check({tag, " res_min"}, res_min, mn);
        check({tag, " res_max"}, res_max, mx);
    endtask

    initial begin
        int seen;
        int last_c;

        for (int i = 0; i < NS; i++) begin
            vec[0].s[i] = W'(i);
            vec[1].s[i] = W'(15 - i);
            vec[2].s[i] = W'(127);
            vec[3].s[i] = (i % 2 == 0) ? W'(100) : W'(5);
            vec[4].s[i] = (i == 7) ? W'(1) : W'(0);
            vec[5].s[i] = W'(i * 8);
        end
        vec[0].sum = 120;  vec[0].mean = 7;   vec[0].mn = 0;   vec[0].mx = 15;
        vec[1].sum = 120;  vec[1].mean = 7;   vec[1].mn = 0;   vec[1].mx = 15;
        vec[2].sum = 2032; vec[2].mean = 127; vec[2].mn = 127; vec[2].mx = 127;
        vec[3].sum = 840;  vec[3].mean = 52;  vec[3].mn = 5;   vec[3].mx = 100;
        vec[4].sum = 1;    vec[4].mean = 0;   vec[4].mn = 0;   vec[4].mx = 1;
        vec[5].sum = 960;  vec[5].mean = 60;  vec[5].mn = 0;   vec[5].mx = 120;

        // Reset, then valid samples without start must be ignored.
        repeat (3) tick();
        check("reset res_sum", res_sum, 0);
        check("reset res_min", res_min, 0);
        check("reset res_val", res_val, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        hw    = W'(5);
        hw_val = 1'b1;
        repeat (20) tick();
        hw_val = 1'b0;
        check("idle res_sum", res_sum, 0);
        check("idle res_max", res_max, 0);
        check("idle res_val", res_val, 0);
        check("idle busy", busy, 0);
        check("idle drop_cnt", drop_cnt, 0);

        // Table of windows, back-to-back samples, consumer not ready until checked.
        for (int v = 0; v < 6; v++) begin
            start_window();
            check($sformatf("vec%0d busy", v), busy, 1);
            for (int i = 0; i < NS; i++) begin
                if (i == NS - 1) check($sformatf("vec%0d early res_val", v), res_val, 0);
                feed(vec[v].s[i]);
            end
            check_result($sformatf("vec%0d", v), vec[v].sum, vec[v].mean, vec[v].mn, vec[v].mx);
            check($sformatf("vec%0d busy in hold", v), busy, 0);
            handshake();
            check($sformatf("vec%0d res_val after hs", v), res_val, 0);
            check($sformatf("vec%0d drop_cnt", v), drop_cnt, 0);
        end

        // Backpressure: 300 samples in HOLD saturate the drop counter.
        start_window();
        for (int i = 0; i < NS; i++) feed(W'(i));
        hw     = W'(9);
        hw_val = 1'b1;
        repeat (300) tick();
        hw_val = 1'b0;
        check("drops saturated", drop_cnt, 255);
        check_result("drops", 120, 7, 0, 15);
        handshake();
        check("drops res_val after hs", res_val, 0);
        check("drops busy after hs", busy, 0);
        repeat (3) feed(W'(2));
        check("drops idle samples ignored", drop_cnt, 255);
        check("drops stays idle", busy, 0);

        // Gaps and en low: en-low samples must be neither absorbed nor dropped.
        start_window();
        check("start clears drop_cnt", drop_cnt, 0);
        for (int i = 0; i < NS; i++) begin
            feed(W'(64));
            tick();
            if (i == 4 || i == 9 || i == 13) begin
                en = 1'b0;
                feed(W'(0));
                en = 1'b1;
            end
        end
        check_result("gaps", 1024, 64, 64, 64);
        en = 1'b0;
        feed(W'(3));
        feed(W'(3));
        en = 1'b1;
        check("en low no drop", drop_cnt, 0);
        check("en low holds result", res_val, 1);
        handshake();
        check("gaps res_val after hs", res_val, 0);

        // Continuous mode: results every 17 cycles, one handshake-cycle drop each.
        cont    = 1'b1;
        res_rdy = 1'b1;
        hw      = W'(32);
        hw_val  = 1'b1;
        seen    = 0;
        last_c  = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (res_val) begin
                check($sformatf("cont%0d cycle", seen), c, 17 * (seen + 1));
                check($sformatf("cont%0d res_sum", seen), res_sum, 512);
                check($sformatf("cont%0d res_mean", seen), res_mean, 32);
                check($sformatf("cont%0d drop_cnt", seen), drop_cnt, seen);
                seen++;
                last_c = c;
            end
        end
        check("cont result count", seen, 3);
        check("cont last result cycle", last_c, 51);
        cont    = 1'b0;
        res_rdy = 1'b0;
        hw_val  = 1'b0;

        // Engine is now 8 samples into a window; reset must clear it asynchronously.
        check("mid-window busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset res_sum", res_sum, 0);
        check("async reset drop_cnt", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        start_window();
        for (int i = 0; i < NS; i++) feed(W'(1));
        check_result("after reset", 16, 1, 1, 1);

        // Reset while holding a result drops res_val without a handshake.
        #2 rst_n = 1'b0;
        #1;
        check("reset in hold res_val", res_val, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after reset idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
